// File: rtl/timer_pkg.sv
// Shared definitions for the countdown timer: state encoding and field defaults.
package timer_pkg;

  // Field width used when the timer is instantiated without an override.
  localparam int WIDTH_DEFAULT = 6;

  // Nominal seconds modulus for a minutes:seconds display.
  localparam logic [5:0] LAW_NOMINAL = 6'd60;

  // Control states of the countdown FSM.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSE   = 2'd2,
    ST_EXPIRED = 2'd3
  } timer_state_t;

endpackage : timer_pkg

// File: rtl/m_down_counter.sv
// Single decrementing field: loads a preset, counts down on en, and wraps
// from 0 to law-1 (modulo 2^WIDTH, so law=0 wraps to all-ones).
module m_down_counter
  import timer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clock,
  input  logic             res,
  input  logic             en,
  input  logic [WIDTH-1:0] law,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             borrow
);

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] wrap_s;

  // Wrap target is law-1; the natural modulo subtraction handles law=0.
  assign wrap_s = law - WIDTH'(1);

  // Field register: load beats decrement; a zero field wraps on decrement.
  always_ff @(posedge clock or negedge res) begin
    if (!res) begin
      q_r <= '0;
    end else if (load) begin
      q_r <= d;
    end else if (en) begin
      if (q_r == '0) begin
        q_r <= wrap_s;
      end else begin
        q_r <= q_r - WIDTH'(1);
      end
    end else begin
      q_r <= q_r;
    end
  end

  assign q      = q_r;
  // Borrow tells the next-higher field that this one is wrapping this cycle.
  assign borrow = en && (q_r == '0);

endmodule : m_down_counter

// File: rtl/m_countdown_timer.sv
// Minutes:seconds countdown timer with start/pause/acknowledge control,
// load with seconds clamping, and a one-cycle done pulse on expiry.
module m_countdown_timer
  import timer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clock,
  input  logic             res,
  input  logic             tick,
  input  logic [WIDTH-1:0] law,
  input  logic             load,
  input  logic [WIDTH-1:0] load_sec,
  input  logic [WIDTH-1:0] load_min,
  input  logic             start_stop,
  output logic [WIDTH-1:0] q_sec,
  output logic [WIDTH-1:0] q_min,
  output logic             running,
  output logic             expired,
  output logic             done
);

  timer_state_t     state_r;
  timer_state_t     next_state_s;
  logic             done_r;

  logic [WIDTH-1:0] sec_s;
  logic [WIDTH-1:0] min_s;
  logic [WIDTH-1:0] wrap_s;
  logic [WIDTH-1:0] load_sec_clamped_s;
  logic [WIDTH-1:0] next_sec_s;
  logic [WIDTH-1:0] next_min_s;
  logic             count_zero_s;
  logic             dec_s;
  logic             sec_borrow_s;
  logic             min_borrow_s;
  logic             hits_zero_s;

  assign wrap_s       = law - WIDTH'(1);
  assign count_zero_s = (sec_s == '0) && (min_s == '0);

  // Clamp the seconds preset into range; law=0 means 2^WIDTH so nothing clamps.
  always_comb begin
    load_sec_clamped_s = load_sec;
    if ((law != '0) && (load_sec >= law)) begin
      load_sec_clamped_s = wrap_s;
    end else begin
      load_sec_clamped_s = load_sec;
    end
  end

  // A tick decrements only in RUN, and only when neither load nor start_stop
  // claims the cycle; a nonzero count is required so 0:00 can never underflow.
  always_comb begin
    dec_s = 1'b0;
    if ((state_r == ST_RUN) && tick && !load && !start_stop && !count_zero_s) begin
      dec_s = 1'b1;
    end else begin
      dec_s = 1'b0;
    end
  end

  // Predict the post-decrement value so expiry is flagged on the same edge.
  always_comb begin
    next_sec_s = sec_s;
    next_min_s = min_s;
    if (sec_s == '0) begin
      next_sec_s = wrap_s;
      next_min_s = min_s - WIDTH'(1);
    end else begin
      next_sec_s = sec_s - WIDTH'(1);
      next_min_s = min_s;
    end
  end

  assign hits_zero_s = dec_s && (next_sec_s == '0) && (next_min_s == '0);

  m_down_counter #(
    .WIDTH(WIDTH)
  ) u_sec (
    .clock (clock),
    .res   (res),
    .en    (dec_s),
    .law   (law),
    .load  (load),
    .d     (load_sec_clamped_s),
    .q     (sec_s),
    .borrow(sec_borrow_s)
  );

  // Minutes never wrap in normal use (the zero guard stops it), so its
  // modulus is left at 2^WIDTH.
  m_down_counter #(
    .WIDTH(WIDTH)
  ) u_min (
    .clock (clock),
    .res   (res),
    .en    (sec_borrow_s),
    .law   ({WIDTH{1'b0}}),
    .load  (load),
    .d     (load_min),
    .q     (min_s),
    .borrow(min_borrow_s)
  );

  // State register.
  always_ff @(posedge clock or negedge res) begin
    if (!res) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic: load overrides everything, then start_stop, then tick.
  always_comb begin
    next_state_s = state_r;
    if (load) begin
      next_state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_stop && !count_zero_s) begin
            next_state_s = ST_RUN;
          end else begin
            next_state_s = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (start_stop) begin
            next_state_s = ST_PAUSE;
          end else if (hits_zero_s || min_borrow_s) begin
            // A minutes borrow would be an underflow; treat it as expiry too.
            next_state_s = ST_EXPIRED;
          end else begin
            next_state_s = ST_RUN;
          end
        end
        ST_PAUSE: begin
          if (start_stop) begin
            next_state_s = ST_RUN;
          end else begin
            next_state_s = ST_PAUSE;
          end
        end
        ST_EXPIRED: begin
          if (start_stop) begin
            next_state_s = ST_IDLE;
          end else begin
            next_state_s = ST_EXPIRED;
          end
        end
        default: begin
          next_state_s = ST_IDLE;
        end
      endcase
    end
  end

  // Done pulse: registered on the edge that first enters EXPIRED.
  always_ff @(posedge clock or negedge res) begin
    if (!res) begin
      done_r <= 1'b0;
    end else begin
      done_r <= (state_r != ST_EXPIRED) && (next_state_s == ST_EXPIRED);
    end
  end

  assign q_sec   = sec_s;
  assign q_min   = min_s;
  assign running = (state_r == ST_RUN);
  assign expired = (state_r == ST_EXPIRED);
  assign done    = done_r;

endmodule : m_countdown_timer

// File: tb/tb_m_countdown_timer.sv
// Scoreboard bench for m_countdown_timer: each stimulus cycle pushes the
// hand-computed outputs expected after its edge; a monitor pops and compares.
module tb_m_countdown_timer;

  logic       clock;
  logic       res;
  logic       tick;
  logic [5:0] law;
  logic       load;
  logic [5:0] load_sec;
  logic [5:0] load_min;
  logic       start_stop;
  logic [5:0] q_sec;
  logic [5:0] q_min;
  logic       running;
  logic       expired;
  logic       done;

  typedef struct {
    logic [5:0] sec;
    logic [5:0] min;
    logic       run;
    logic       exp;
    logic       dn;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  m_countdown_timer #(.WIDTH(6)) dut (
    .clock     (clock),
    .res       (res),
    .tick      (tick),
    .law       (law),
    .load      (load),
    .load_sec  (load_sec),
    .load_min  (load_min),
    .start_stop(start_stop),
    .q_sec     (q_sec),
    .q_min     (q_min),
    .running   (running),
    .expired   (expired),
    .done      (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic compare(input exp_t e);
    checks++;
    if (q_sec !== e.sec || q_min !== e.min || running !== e.run ||
        expired !== e.exp || done !== e.dn) begin
      errors++;
      $display("FAIL %s: got %0d:%0d run=%0b exp=%0b done=%0b, want %0d:%0d run=%0b exp=%0b done=%0b",
               e.name, q_min, q_sec, running, expired, done,
               e.min, e.sec, e.run, e.exp, e.dn);
    end
  endtask

  // Monitor: one expected entry is consumed just after each active edge.
  always @(posedge clock) begin
    #1;
    if (exp_q.size() > 0) begin
      compare(exp_q.pop_front());
    end
  end

  // Drive one cycle of inputs and record the outputs expected after its edge.
  task automatic step(input logic ld, input logic ss, input logic tk,
                      input logic [5:0] lw, input logic [5:0] ls, input logic [5:0] lm,
                      input logic [5:0] es, input logic [5:0] em,
                      input logic er, input logic ee, input logic ed, input string nm);
    exp_t e;
    @(negedge clock);
    load       = ld;
    start_stop = ss;
    tick       = tk;
    law        = lw;
    load_sec   = ls;
    load_min   = lm;
    e.sec = es; e.min = em; e.run = er; e.exp = ee; e.dn = ed; e.name = nm;
    exp_q.push_back(e);
  endtask

  initial begin
    exp_t e;
    res = 1'b0; tick = 1'b0; load = 1'b0; start_stop = 1'b0;
    law = 6'd60; load_sec = 6'd0; load_min = 6'd0;
    #1;
    e.sec = 6'd0; e.min = 6'd0; e.run = 1'b0; e.exp = 1'b0; e.dn = 1'b0; e.name = "reset_init";
    compare(e);
    @(negedge clock);
    res = 1'b1;

    // Load 1:05, start, six ticks crossing the minute borrow.
    step(1'b1, 1'b0, 1'b0, 6'd60, 6'd5, 6'd1,  6'd5,  6'd1, 1'b0, 1'b0, 1'b0, "load_1_05");
    step(1'b0, 1'b1, 1'b0, 6'd60, 6'd5, 6'd1,  6'd5,  6'd1, 1'b1, 1'b0, 1'b0, "start_1_05");
    step(1'b0, 1'b0, 1'b1, 6'd60, 6'd0, 6'd0,  6'd4,  6'd1, 1'b1, 1'b0, 1'b0, "tick_1_04");
    step(1'b0, 1'b0, 1'b1, 6'd60, 6'd0, 6'd0,  6'd3,  6'd1, 1'b1, 1'b0, 1'b0, "tick_1_03");
    step(1'b0, 1'b0, 1'b1, 6'd60, 6'd0, 6'd0,  6'd2,  6'd1, 1'b1, 1'b0, 1'b0, "tick_1_02");
    step(1'b0, 1'b0, 1'b1, 6'd60, 6'd0, 6'd0,  6'd1,  6'd1, 1'b1, 1'b0, 1'b0, "tick_1_01");
    step(1'b0, 1'b0, 1'b1, 6'd60, 6'd0, 6'd0,  6'd0,  6'd1, 1'b1, 1'b0, 1'b0, "tick_1_00");
    step(1'b0, 1'b0, 1'b1, 6'd60, 6'd0, 6'd0,  6'd59, 6'd0, 1'b1, 1'b0, 1'b0, "borrow_0_59");

    // Expiry at 0:00 with a single done pulse, then acknowledge.
    step(1'b1, 1'b0, 1'b0, 6'd60, 6'd2, 6'd0,  6'd2, 6'd0, 1'b0, 1'b0, 1'b0, "load_0_02");
    step(1'b0, 1'b1, 1'b0, 6'd60, 6'd0, 6'd0,  6'd2, 6'd0, 1'b1, 1'b0, 1'b0, "start_0_02");
    step(1'b0, 1'b0, 1'b1, 6'd60, 6'd0, 6'd0,  6'd1, 6'd0, 1'b1, 1'b0, 1'b0, "tick_0_01");
    step(1'b0, 1'b0, 1'b1, 6'd60, 6'd0, 6'd0,  6'd0, 6'd0, 1'b0, 1'b1, 1'b1, "expire_done");
    step(1'b0, 1'b0, 1'b1, 6'd60, 6'd0, 6'd0,  6'd0, 6'd0, 1'b0, 1'b1, 1'b0, "expired_tick_hold");
    step(1'b0, 1'b0, 1'b0, 6'd60, 6'd0, 6'd0,  6'd0, 6'd0, 1'b0, 1'b1, 1'b0, "expired_idle_cycle");
    step(1'b0, 1'b1, 1'b0, 6'd60, 6'd0, 6'd0,  6'd0, 6'd0, 1'b0, 1'b0, 1'b0, "ack_to_idle");

    // Pause with a coincident tick, ticks ignored while paused, resume.
    step(1'b1, 1'b0, 1'b0, 6'd60, 6'd30, 6'd0, 6'd30, 6'd0, 1'b0, 1'b0, 1'b0, "load_0_30");
    step(1'b0, 1'b1, 1'b0, 6'd60, 6'd0,  6'd0, 6'd30, 6'd0, 1'b1, 1'b0, 1'b0, "start_0_30");
    step(1'b0, 1'b1, 1'b1, 6'd60, 6'd0,  6'd0, 6'd30, 6'd0, 1'b0, 1'b0, 1'b0, "pause_with_tick");
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b1, 6'd60, 6'd0, 6'd0, 6'd30, 6'd0, 1'b0, 1'b0, 1'b0, "paused_tick");
    end
    step(1'b0, 1'b1, 1'b0, 6'd60, 6'd0,  6'd0, 6'd30, 6'd0, 1'b1, 1'b0, 1'b0, "resume");
    step(1'b0, 1'b0, 1'b1, 6'd60, 6'd0,  6'd0, 6'd29, 6'd0, 1'b1, 1'b0, 1'b0, "resume_tick_0_29");

    // Clamp and modulus corner cases.
    step(1'b1, 1'b0, 1'b0, 6'd60, 6'd61, 6'd0, 6'd59, 6'd0, 1'b0, 1'b0, 1'b0, "clamp_61_to_59");
    step(1'b1, 1'b0, 1'b0, 6'd0,  6'd0,  6'd1, 6'd0,  6'd1, 1'b0, 1'b0, 1'b0, "law0_load_1_00");
    step(1'b0, 1'b1, 1'b0, 6'd0,  6'd0,  6'd0, 6'd0,  6'd1, 1'b1, 1'b0, 1'b0, "law0_start");
    step(1'b0, 1'b0, 1'b1, 6'd0,  6'd0,  6'd0, 6'd63, 6'd0, 1'b1, 1'b0, 1'b0, "law0_wrap_0_63");
    step(1'b1, 1'b0, 1'b0, 6'd1,  6'd5,  6'd2, 6'd0,  6'd2, 1'b0, 1'b0, 1'b0, "law1_clamp_0_02");
    step(1'b0, 1'b1, 1'b0, 6'd1,  6'd0,  6'd0, 6'd0,  6'd2, 1'b1, 1'b0, 1'b0, "law1_start");
    step(1'b0, 1'b0, 1'b1, 6'd1,  6'd0,  6'd0, 6'd0,  6'd1, 1'b1, 1'b0, 1'b0, "law1_tick_1_00");
    step(1'b0, 1'b0, 1'b1, 6'd1,  6'd0,  6'd0, 6'd0,  6'd0, 1'b0, 1'b1, 1'b1, "law1_expire");
    step(1'b0, 1'b1, 1'b0, 6'd60, 6'd0,  6'd0, 6'd0,  6'd0, 1'b0, 1'b0, 1'b0, "law1_ack");

    // Priority: load beats start_stop and tick; IDLE ignores tick; 0:00 won't start.
    step(1'b1, 1'b1, 1'b1, 6'd60, 6'd10, 6'd0, 6'd10, 6'd0, 1'b0, 1'b0, 1'b0, "load_wins");
    step(1'b0, 1'b0, 1'b1, 6'd60, 6'd0,  6'd0, 6'd10, 6'd0, 1'b0, 1'b0, 1'b0, "idle_tick_ignored");
    step(1'b1, 1'b0, 1'b0, 6'd60, 6'd0,  6'd0, 6'd0,  6'd0, 1'b0, 1'b0, 1'b0, "load_0_00");
    step(1'b0, 1'b1, 1'b0, 6'd60, 6'd0,  6'd0, 6'd0,  6'd0, 1'b0, 1'b0, 1'b0, "start_at_zero_ignored");
    step(1'b0, 1'b0, 1'b1, 6'd60, 6'd0,  6'd0, 6'd0,  6'd0, 1'b0, 1'b0, 1'b0, "zero_idle_tick");

    // Asynchronous reset between edges while running.
    step(1'b1, 1'b0, 1'b0, 6'd60, 6'd20, 6'd3, 6'd20, 6'd3, 1'b0, 1'b0, 1'b0, "load_3_20");
    step(1'b0, 1'b1, 1'b0, 6'd60, 6'd0,  6'd0, 6'd20, 6'd3, 1'b1, 1'b0, 1'b0, "start_3_20");
    step(1'b0, 1'b0, 1'b1, 6'd60, 6'd0,  6'd0, 6'd19, 6'd3, 1'b1, 1'b0, 1'b0, "tick_3_19");
    @(posedge clock);
    #2;
    tick = 1'b0;
    res  = 1'b0;
    #1;
    e.sec = 6'd0; e.min = 6'd0; e.run = 1'b0; e.exp = 1'b0; e.dn = 1'b0; e.name = "async_reset";
    compare(e);
    @(negedge clock);
    res = 1'b1;
    step(1'b0, 1'b0, 1'b1, 6'd60, 6'd0, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, "post_reset_tick");
    step(1'b0, 1'b1, 1'b0, 6'd60, 6'd0, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, "post_reset_start");
    step(1'b0, 1'b0, 1'b1, 6'd60, 6'd0, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, "post_reset_idle");
    step(1'b0, 1'b0, 1'b0, 6'd60, 6'd0, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, "final_idle");

    // Every pushed expectation must have been consumed by the monitor.
    repeat (3) @(negedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_m_countdown_timer

// File: doc/m_countdown_timer.md
# m_countdown_timer

Countdown timer for the adjustable clock: the decrementing counterpart of the up-counting time chain. It holds a minutes:seconds value, decrements it once per `tick` enable, borrows from minutes when seconds wrap, and flags expiry at 0:00. Start/pause/reset control comes from debounced button pulses, and its outputs drive the same 7-segment display path as the clock counters.

## Interface
Parameters:
- `WIDTH`, 6: width of each of the seconds and minutes fields.

Ports:
- `clock`  in  1  system clock; all state changes on its rising edge.
- `res`  in  1  asynchronous, active-low reset.
- `tick`  in  1  one-cycle decrement enable from the prescaler (1 Hz nominal).
- `law`  in  WIDTH  seconds modulus (60 nominal); the seconds field wraps to `law-1`.
- `load`  in  1  one-cycle pulse; captures `load_sec`/`load_min`.
- `load_sec`  in  WIDTH  seconds preset.
- `load_min`  in  WIDTH  minutes preset.
- `start_stop`  in  1  one-cycle pulse; run/pause/acknowledge control.
- `q_sec`  out  WIDTH  current seconds.
- `q_min`  out  WIDTH  current minutes.
- `running`  out  1  high in RUN.
- `expired`  out  1  level; high in EXPIRED.
- `done`  out  1  one-cycle pulse on the edge that enters EXPIRED.

## Operation
- States: IDLE, RUN, PAUSE, EXPIRED. Reset gives IDLE, `q_sec=0`, `q_min=0`, `running=0`, `expired=0`, `done=0`.
- Priority per cycle: `res` > `load` > `start_stop` > `tick`.
- `load` in any state:
  - `q_min<=load_min`.
  - `q_sec<=load_sec`, clamped to `law-1` if `load_sec>=law`.
  - Next state IDLE; `expired` clears.
- IDLE:
  - `start_stop` with count ≠ 0:00 goes to RUN.
  - `start_stop` with count = 0:00 is ignored.
  - `tick` is ignored.
- RUN, on `tick`:
  - If `q_sec>0`, then `q_sec--`.
  - Otherwise, if `q_min>0`, then `q_sec<=law-1` and `q_min--` (borrow).
  - If the post-decrement value is 0:00, go to EXPIRED and assert `done` for that one cycle.
- RUN, on `start_stop`: go to PAUSE. A `tick` in the same cycle is discarded.
- PAUSE:
  - `start_stop` goes to RUN.
  - `tick` is ignored; the count holds.
- EXPIRED:
  - Count holds at 0:00 and further ticks are ignored.
  - `start_stop` goes to IDLE and clears `expired`.
- Width rules:
  - All arithmetic is modulo 2^WIDTH.
  - `law=0` is treated as 2^WIDTH, so the wrap value is all-ones.
  - `law=1` forces seconds to 0, so the count decrements minutes only.
- `law` changing mid-run affects only the next wrap and clamp. An in-range `q_sec` above the new `law-1` is left as is and decrements normally.

## Timing
- All outputs are registered. Responses appear one rising edge after the qualifying input cycle.
- `done` is high exactly one cycle, coincident with the first cycle `expired=1`.
- `running` tracks the state register with no extra latency.
- Asserting `res` low mid-count forces reset values immediately (asynchronous). Release is synchronous-safe: the first active edge after release sees IDLE.
- Back-to-back `tick` on consecutive cycles is legal; each decrements once.

## Structure
- Shared package (`timer_pkg`):
  - State encoding constants: IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, EXPIRED=2'd3.
  - `WIDTH` default.
  - Nominal `law` constant 6'd60.
- Sub-module `m_down_counter` (one instance per field), the decrementing dual of the up counter:
  - Inputs: `clock`, `res`, `en`, `law`, `load`, `d`.
  - Outputs: `q` and a combinational `borrow` (en && q==0).
  - Seconds `borrow` gates the minutes `en`.
- Top-level FSM: gating, clamp, and zero detect.

## Test plan
- Reset, then `load` 1:05 with `law=60`, `start_stop`, 6 ticks: sequence 1:04..1:00 then 0:59; `running=1`, `done=0`.
- `load` 0:02 plus `start_stop`, 2 ticks: second tick gives 0:00, `expired=1`, one-cycle `done`. Third tick keeps 0:00 with no `done`. `start_stop` returns to IDLE with `expired=0`.
- RUN at 0:30: `start_stop` and `tick` in the same cycle gives PAUSE and the count stays 0:30. Three ticks leave it unchanged. `start_stop` resumes and the next tick gives 0:29.
- `load_sec=61` with `law=60` loads 59. With `law=0`, 1:00 plus one tick gives 0:63.
- `load`, `start_stop` and `tick` all asserted in one cycle: load wins, state IDLE, value equals the preset. `start_stop` at a 0:00 preset stays IDLE.
- `res` driven low mid-RUN between edges: outputs go to 0 asynchronously. After release, state is IDLE and ticks are ignored.
